// File: rtl/ahb_regbank_hs.sv
// AHB-Lite register bank bridging firmware to user logic via a synchronised 4-phase req/ack handshake.
// Latency: zero wait states; writes land on the edge ending the data phase; reads are combinational in the data phase.
// Backpressure: none; HREADY is always 1 and HRESP always OKAY, so GO while busy is dropped and flagged as overrun.
//
// Ports:
//   AHB_HCLK / AHB_HRESETn       bus clock, asynchronous active-low reset
//   AHB_H*                       AHB-Lite slave interface (HBURST/HPROT/HMASTER/HMASTLOCK ignored)
//   usr_req / usr_ack            handshake toward user logic (ack is asynchronous)
//   usr_init                     asynchronous user-side init-done flag, visible as STATUS bit3
//   usr_wr_data / usr_rd_data    flattened RW registers out, user data in (reg i at [32i+31:32i])
//   irq                          registered level interrupt = done & irq_en
module ahb_regbank_hs #(
    parameter int NUM_WR_REGS = 4,
    parameter int NUM_RD_REGS = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      AHB_HCLK,
    input  logic                      AHB_HRESETn,
    input  logic                      AHB_HSEL,
    input  logic                      AHB_HWRITE,
    input  logic [1:0]                AHB_HTRANS,
    input  logic [2:0]                AHB_HSIZE,
    input  logic [31:0]               AHB_HADDR,
    input  logic [31:0]               AHB_HWDATA,
    input  logic [2:0]                AHB_HBURST,
    input  logic [3:0]                AHB_HPROT,
    input  logic [3:0]                AHB_HMASTER,
    input  logic                      AHB_HMASTLOCK,
    output logic [31:0]               AHB_HRDATA,
    output logic                      AHB_HREADY,
    output logic                      AHB_HRESP,
    output logic                      usr_req,
    input  logic                      usr_ack,
    input  logic                      usr_init,
    output logic [32*NUM_WR_REGS-1:0] usr_wr_data,
    input  logic [32*NUM_RD_REGS-1:0] usr_rd_data,
    output logic                      irq
);

    localparam int RD_BASE = 2 + NUM_WR_REGS;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DROP} state_t;

    state_t      state;
    logic        dp_vld;
    logic        dp_write;
    logic [11:0] dp_addr;
    logic [2:0]  dp_size;
    logic [9:0]  idx;
    int          idx_i;
    logic [3:0]  be;
    logic        wr_act;
    logic        rd_act;
    logic        busy;
    logic        go_wr;
    logic        st_wr;
    logic        done;
    logic        ovr;
    logic        irq_en;
    logic        done_nxt;
    logic        ovr_nxt;
    logic [SYNC_STAGES-1:0] ack_ff;
    logic [SYNC_STAGES-1:0] init_ff;
    logic        ack_sync;
    logic        init_sync;
    logic [31:0] wr_regs [NUM_WR_REGS];
    logic [31:0] rd_regs [NUM_RD_REGS];

    logic unused_ok;
    assign unused_ok = ^{AHB_HBURST, AHB_HPROT, AHB_HMASTER, AHB_HMASTLOCK,
                         AHB_HADDR[31:12], AHB_HTRANS[0]};

    assign AHB_HREADY = 1'b1;
    assign AHB_HRESP  = 1'b0;

    // Address phase capture; HREADY is tied high so every cycle is a sampling cycle.
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            dp_vld   <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_size  <= '0;
        end else begin
            dp_vld <= AHB_HSEL & AHB_HTRANS[1];
            if (AHB_HSEL & AHB_HTRANS[1]) begin
                dp_write <= AHB_HWRITE;
                dp_addr  <= AHB_HADDR[11:0];
                dp_size  <= AHB_HSIZE;
            end
        end
    end

    // Input synchronisers; output is the last stage.
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            ack_ff  <= '0;
            init_ff <= '0;
        end else begin
            ack_ff  <= {ack_ff[SYNC_STAGES-2:0], usr_ack};
            init_ff <= {init_ff[SYNC_STAGES-2:0], usr_init};
        end
    end
    assign ack_sync  = ack_ff[SYNC_STAGES-1];
    assign init_sync = init_ff[SYNC_STAGES-1];

    assign idx    = dp_addr[11:2];
    assign idx_i  = {22'd0, idx};
    assign wr_act = dp_vld & dp_write;
    assign rd_act = dp_vld & ~dp_write;
    assign busy   = (state != ST_IDLE);

    always_comb begin
        case (dp_size)
            3'd0:    be = 4'b0001 << dp_addr[1:0];
            3'd1:    be = dp_addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // All CTRL/STATUS control bits live in byte lane 0.
    assign go_wr = wr_act && (idx_i == 0) && be[0] && AHB_HWDATA[0];
    assign st_wr = wr_act && (idx_i == 1) && be[0];

    // Set beats W1C when both occur in the same cycle.
    assign done_nxt = (done & ~(st_wr & AHB_HWDATA[1])) | ((state == ST_DROP) & ~ack_sync);
    assign ovr_nxt  = (ovr  & ~(st_wr & AHB_HWDATA[2])) | (go_wr & busy);

    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            for (int i = 0; i < NUM_WR_REGS; i++) wr_regs[i] <= '0;
        end else if (wr_act) begin
            for (int i = 0; i < NUM_WR_REGS; i++) begin
                if (idx_i == i + 2) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) wr_regs[i][8*b +: 8] <= AHB_HWDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    // Handshake FSM with status, interrupt and shadow capture.
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            state   <= ST_IDLE;
            usr_req <= 1'b0;
            done    <= 1'b0;
            ovr     <= 1'b0;
            irq_en  <= 1'b0;
            irq     <= 1'b0;
            for (int i = 0; i < NUM_RD_REGS; i++) rd_regs[i] <= '0;
        end else begin
            done <= done_nxt;
            ovr  <= ovr_nxt;
            irq  <= done & irq_en;
            if (wr_act && (idx_i == 0) && be[0]) irq_en <= AHB_HWDATA[1];
            case (state)
                ST_IDLE: begin
                    if (go_wr) begin
                        state   <= ST_REQ;
                        usr_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ack_sync) begin
                        state   <= ST_DROP;
                        usr_req <= 1'b0;
                        for (int i = 0; i < NUM_RD_REGS; i++) rd_regs[i] <= usr_rd_data[32*i +: 32];
                    end
                end
                ST_DROP: begin
                    if (!ack_sync) state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    usr_req <= 1'b0;
                end
            endcase
        end
    end

    // Read mux: all-ones whenever no read data phase is active or the index is unmapped.
    always_comb begin
        AHB_HRDATA = '1;
        if (rd_act) begin
            if (idx_i == 0) AHB_HRDATA = {30'd0, irq_en, busy};
            if (idx_i == 1) AHB_HRDATA = {28'd0, init_sync, ovr, done, busy};
            for (int i = 0; i < NUM_WR_REGS; i++) begin
                if (idx_i == i + 2) AHB_HRDATA = wr_regs[i];
            end
            for (int i = 0; i < NUM_RD_REGS; i++) begin
                if (idx_i == i + RD_BASE) AHB_HRDATA = rd_regs[i];
            end
        end
    end

    always_comb begin
        usr_wr_data = '0;
        for (int i = 0; i < NUM_WR_REGS; i++) usr_wr_data[32*i +: 32] = wr_regs[i];
    end

endmodule
